// File: rtl/gin_feeder.sv
// gin_feeder: tags buffer read words with a raster-scanned (row, col) pair and queues them toward GIN.
// Ports:
//   clk, reset (async, active-low)
//   cfg_start, cfg_row_first/last, cfg_col_first/last : transfer setup, sampled in IDLE
//   busy, done, cfg_err                               : transfer status
//   in_data, in_valid, in_ready                       : global buffer read stream
//   gin_data, gin_row_tag, gin_col_tag, gin_enable, gin_ready : tagged stream toward GIN
module gin_feeder #(
   parameter int DATA_WIDTH    = 64,
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_start,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_first,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_row_last,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_first,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_last,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_WIDTH-1:0]    gin_data,
   output logic [ROW_TAG_WIDTH-1:0] gin_row_tag,
   output logic [COL_TAG_WIDTH-1:0] gin_col_tag,
   output logic                     gin_enable,
   input  logic                     gin_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + ROW_TAG_WIDTH + COL_TAG_WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
   state_t state, state_nx;
   logic [ROW_TAG_WIDTH-1:0] row_cnt, row_last_q;
   logic [COL_TAG_WIDTH-1:0] col_cnt, col_first_q, col_last_q;
   logic err_q, bad_rect, last_tag, push, pop, empty, full;
   logic [AW:0] wr_ptr, rd_ptr, occ;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head, last_q;
   assign bad_rect = (cfg_row_first > cfg_row_last) || (cfg_col_first > cfg_col_last);
   assign last_tag = (row_cnt == row_last_q) && (col_cnt == col_last_q);
   // pointers carry one extra wrap bit, so occupancy == FIFO_DEPTH sets exactly the top bit
   assign occ      = wr_ptr - rd_ptr;
   assign empty    = (occ == '0);
   assign full     = occ[AW];
   // no push while full, even on a same-cycle pop: keeps in_ready independent of gin_ready
   assign in_ready = (state == RUN) && !full;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && gin_ready;
   assign head     = mem[rd_ptr[AW-1:0]];
   // last_q holds the most recently delivered word so the payload freezes while empty
   assign {gin_data, gin_row_tag, gin_col_tag} = empty ? last_q : head;
   assign gin_enable = !empty;
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == FIN);
   assign cfg_err    = done && err_q;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (cfg_start) state_nx = bad_rect ? FIN : RUN;
         RUN:   if (push && last_tag) state_nx = DRAIN;
         DRAIN: if (pop && occ == (AW+1)'(1)) state_nx = FIN;
         FIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         row_cnt     <= '0;
         col_cnt     <= '0;
         row_last_q  <= '0;
         col_first_q <= '0;
         col_last_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cfg_start) begin
            row_cnt     <= cfg_row_first;
            col_cnt     <= cfg_col_first;
            row_last_q  <= cfg_row_last;
            col_first_q <= cfg_col_first;
            col_last_q  <= cfg_col_last;
            err_q       <= bad_rect;
         end else if (push && !last_tag) begin
            // counters stop on the final tag, so they never wrap even for a full-range rectangle
            if (col_cnt == col_last_q) begin
               col_cnt <= col_first_q;
               row_cnt <= row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= head;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_data, row_cnt, col_cnt};
   end
endmodule

// File: tb/tb_gin_feeder.sv
// tb_gin_feeder: table-driven transfers with a scoreboard of tagged words, plus reset corner cases.
module tb_gin_feeder;
   localparam int DW = 64;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset, cfg_start, in_valid, gin_ready;
   logic [3:0] cfg_row_first, cfg_row_last, cfg_col_first, cfg_col_last;
   logic busy, done, cfg_err, in_ready, gin_enable;
   logic [DW-1:0] in_data, gin_data;
   logic [3:0] gin_row_tag, gin_col_tag;
   int checks = 0;
   int failures = 0;
   logic [31:0] dcnt = 32'h1000;

   typedef struct {
      logic [3:0] rf, rl, cf, cl;
      int stall;
      int restart;
      logic err;
   } vec_t;
   typedef struct {
      logic [DW-1:0] d;
      logic [3:0] r, c;
   } ent_t;
   ent_t sb[$];
   vec_t vecs[6];

   gin_feeder dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start),
      .cfg_row_first(cfg_row_first), .cfg_row_last(cfg_row_last),
      .cfg_col_first(cfg_col_first), .cfg_col_last(cfg_col_last),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .gin_data(gin_data), .gin_row_tag(gin_row_tag), .gin_col_tag(gin_col_tag),
      .gin_enable(gin_enable), .gin_ready(gin_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_xfer(input vec_t v);
      int cyc, acc, outn, exp_n;
      logic [3:0] mr, mc, pr, pc;
      logic [DW-1:0] pd;
      logic prev_in, prev_last, prev_stall, in_hs, out_hs, exp_done, fin;
      ent_t e;
      exp_n = v.err ? 0 : (int'(v.rl) - int'(v.rf) + 1) * (int'(v.cl) - int'(v.cf) + 1);
      mr = v.rf;
      mc = v.cf;
      sb.delete();
      gin_ready = (v.stall == 0);
      cfg_row_first = v.rf;
      cfg_row_last = v.rl;
      cfg_col_first = v.cf;
      cfg_col_last = v.cl;
      cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
      cyc = 0; acc = 0; outn = 0; fin = 0;
      prev_in = 0; prev_last = 0; prev_stall = 0;
      pd = '0; pr = '0; pc = '0;
      while (!fin && cyc < 400) begin
         @(negedge clk);
         cyc++;
         exp_done = v.err ? (cyc == 1) : prev_last;
         chk("done", done, exp_done);
         chk("cfg_err", cfg_err, v.err && exp_done);
         chk("busy", busy, !v.err && !exp_done);
         if (prev_in) chk("fwft_enable", gin_enable, 1);
         if (prev_stall) begin
            chk("stall_enable", gin_enable, 1);
            chk("stall_data", gin_data, pd);
            chk("stall_row", gin_row_tag, pr);
            chk("stall_col", gin_col_tag, pc);
         end
         if (acc == exp_n) chk("in_ready_off", in_ready, 0);
         if (v.stall == 10 && cyc == 10) begin
            chk("stall_accepted", acc, DEPTH);
            chk("stall_in_ready", in_ready, 0);
         end
         in_hs = in_valid && in_ready;
         out_hs = gin_enable && gin_ready;
         prev_last = 0;
         if (out_hs) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_data", gin_data, e.d);
               chk("out_row", gin_row_tag, e.r);
               chk("out_col", gin_col_tag, e.c);
            end
            outn++;
            prev_last = (outn == exp_n);
         end
         if (in_hs) begin
            e.d = in_data;
            e.r = mr;
            e.c = mc;
            sb.push_back(e);
            acc++;
            if (mc == v.cl) begin
               mc = v.cf;
               mr = mr + 1'b1;
            end else begin
               mc = mc + 1'b1;
            end
         end
         if (done) begin
            chk("accepted", acc, exp_n);
            chk("delivered", outn, exp_n);
            fin = 1;
            cfg_start = 1'b1;
         end
         prev_in = in_hs;
         prev_stall = gin_enable && !gin_ready;
         pd = gin_data;
         pr = gin_row_tag;
         pc = gin_col_tag;
         @(posedge clk);
         #1 cfg_start = 1'b0;
         if (in_hs) begin
            dcnt = dcnt + 1;
            in_data = {dcnt, ~dcnt};
         end
         gin_ready = (cyc + 1 > v.stall);
         if (cyc + 1 == v.restart) begin
            cfg_start = 1'b1;
            cfg_row_first = 4'd9;
            cfg_row_last = 4'd12;
            cfg_col_first = 4'd5;
            cfg_col_last = 4'd6;
         end
      end
      if (!fin) chk("timeout", 1, 0);
      @(negedge clk);
      chk("fin_start_ignored_busy", busy, 0);
      chk("fin_start_ignored_done", done, 0);
   endtask

   initial begin
      reset = 1'b1;
      cfg_start = 1'b0;
      in_valid = 1'b0;
      gin_ready = 1'b0;
      in_data = {dcnt, ~dcnt};
      cfg_row_first = '0; cfg_row_last = '0; cfg_col_first = '0; cfg_col_last = '0;
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_enable", gin_enable, 0);
      chk("rst_data", gin_data, 0);
      chk("rst_tags", {gin_row_tag, gin_col_tag}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b1;
      vecs[0] = '{rf: 2, rl: 3, cf: 0, cl: 2, stall: 0,  restart: 0, err: 0};
      vecs[1] = '{rf: 2, rl: 3, cf: 0, cl: 2, stall: 10, restart: 0, err: 0};
      vecs[2] = '{rf: 5, rl: 4, cf: 0, cl: 0, stall: 0,  restart: 0, err: 1};
      vecs[3] = '{rf: 7, rl: 7, cf: 9, cl: 9, stall: 0,  restart: 0, err: 0};
      vecs[4] = '{rf: 0, rl: 3, cf: 0, cl: 3, stall: 0,  restart: 3, err: 0};
      vecs[5] = '{rf: 1, rl: 1, cf: 3, cl: 0, stall: 0,  restart: 0, err: 1};
      for (int i = 0; i < 6; i++) run_xfer(vecs[i]);
      gin_ready = 1'b0;
      cfg_row_first = 4'd0; cfg_row_last = 4'd3;
      cfg_col_first = 4'd0; cfg_col_last = 4'd3;
      @(posedge clk);
      #1 cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pre_rst_in_ready", in_ready, 1);
      end
      @(posedge clk);
      #2;
      chk("pre_rst_enable", gin_enable, 1);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("async_rst_enable", gin_enable, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_in_ready", in_ready, 0);
      chk("async_rst_data", gin_data, 0);
      @(negedge clk);
      reset = 1'b1;
      run_xfer(vecs[0]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
